// File: rtl/cu_decode_pkg.sv
// Shared opcode, state and channel definitions for the registered instruction decoder.
package cu_decode_pkg;

    localparam int OP_BITS = 3;

    localparam logic [OP_BITS-1:0] OP_MOVE     = 3'b000;
    localparam logic [OP_BITS-1:0] OP_IMM      = 3'b001;
    localparam logic [OP_BITS-1:0] OP_IMM_LONG = 3'b010;
    localparam logic [OP_BITS-1:0] OP_JUMP     = 3'b011;
    localparam logic [OP_BITS-1:0] OP_BRANCH   = 3'b100;

    typedef enum logic [1:0] {
        S_DECODE,
        S_LONG_WAIT,
        S_OUT
    } cu_dec_state_t;

    typedef enum logic [1:0] {
        CH_MOVE,
        CH_IMM,
        CH_JUMP,
        CH_BRANCH
    } cu_dec_ch_t;

endpackage

// File: rtl/cu_decode_fields.sv
// Combinational field extraction and opcode classification for one instruction word.
module cu_decode_fields
    import cu_decode_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int JUMP_PTR_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] to_addr,
    output logic [ADDR_WIDTH-1:0] from_addr,
    output logic [DATA_WIDTH-1:0] short_imm,
    output logic [DATA_WIDTH-1:0] jump_ptr,
    output logic [DATA_WIDTH-1:0] branch_ptr,
    output logic                  is_single,
    output logic                  is_long,
    output cu_dec_ch_t            ch
);

    logic [OP_BITS-1:0] op;

    assign op         = data[OP_BITS-1:0];
    assign to_addr    = data[ADDR_WIDTH+2:3];
    assign from_addr  = data[2*ADDR_WIDTH+2:ADDR_WIDTH+3];
    assign short_imm  = {{(ADDR_WIDTH+3){1'b0}}, data[DATA_WIDTH-1:ADDR_WIDTH+3]};
    assign jump_ptr   = {{(DATA_WIDTH-JUMP_PTR_WIDTH){1'b0}}, data[JUMP_PTR_WIDTH+2:3]};
    assign branch_ptr = {{OP_BITS{1'b0}}, data[DATA_WIDTH-1:3]};

    // Classify the opcode: single-word op with its channel, long-immediate header, or neither (illegal).
    always_comb begin
        is_single = 1'b0;
        is_long   = 1'b0;
        ch        = CH_MOVE;
        case (op)
            OP_MOVE:     begin is_single = 1'b1; ch = CH_MOVE;   end
            OP_IMM:      begin is_single = 1'b1; ch = CH_IMM;    end
            OP_IMM_LONG: begin is_long   = 1'b1; ch = CH_IMM;    end
            OP_JUMP:     begin is_single = 1'b1; ch = CH_JUMP;   end
            OP_BRANCH:   begin is_single = 1'b1; ch = CH_BRANCH; end
            default:     ;
        endcase
    end

endmodule

// File: rtl/cu_pipelined_instr_decode.sv
// Registered instruction decoder: one outstanding decoded instruction held until acknowledged,
// two-word long immediates, and a saturating illegal-opcode counter.
module cu_pipelined_instr_decode
    import cu_decode_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int JUMP_PTR_WIDTH = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    // fetched instruction words
    input  logic [DATA_WIDTH-1:0] raw_instr_data,
    input  logic                  raw_instr_valid,
    output logic                  raw_instr_ack,
    // jump target
    output logic [DATA_WIDTH-1:0] jump_ptr,
    output logic                  jump_valid,
    input  logic                  jump_ack,
    // branch target
    output logic [DATA_WIDTH-1:0] branch_ptr,
    output logic                  branch_valid,
    input  logic                  branch_ack,
    // move / immediate issue
    output logic                  move_valid,
    output logic [ADDR_WIDTH-1:0] move_from,
    output logic [ADDR_WIDTH-1:0] move_to,
    input  logic                  move_ack,
    output logic                  immediate_valid,
    output logic [ADDR_WIDTH-1:0] immediate_addr,
    output logic [DATA_WIDTH-1:0] immediate,
    input  logic                  immediate_ack,
    // illegal-opcode reporting
    output logic                  illegal,
    output logic [CNT_WIDTH-1:0]  illegal_count
);

    cu_dec_state_t         state_q, state_d;
    cu_dec_ch_t            ch_q, ch_d;
    logic [ADDR_WIDTH-1:0] to_q, to_d;
    logic [ADDR_WIDTH-1:0] from_q, from_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;
    logic                  illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] f_to, f_from;
    logic [DATA_WIDTH-1:0] f_simm, f_jptr, f_bptr;
    logic                  f_single, f_long;
    cu_dec_ch_t            f_ch;
    logic                  ch_ack;
    logic                  out_vld;

    cu_decode_fields #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .JUMP_PTR_WIDTH(JUMP_PTR_WIDTH)
    ) u_fields (
        .data      (raw_instr_data),
        .to_addr   (f_to),
        .from_addr (f_from),
        .short_imm (f_simm),
        .jump_ptr  (f_jptr),
        .branch_ptr(f_bptr),
        .is_single (f_single),
        .is_long   (f_long),
        .ch        (f_ch)
    );

    // Select the ack belonging to the channel currently being presented; other acks are ignored.
    always_comb begin
        ch_ack = 1'b0;
        case (ch_q)
            CH_MOVE:   ch_ack = move_ack;
            CH_IMM:    ch_ack = immediate_ack;
            CH_JUMP:   ch_ack = jump_ack;
            CH_BRANCH: ch_ack = branch_ack;
            default:   ch_ack = 1'b0;
        endcase
    end

    // Next-state logic: accept words in S_DECODE/S_LONG_WAIT, hold the output register in S_OUT.
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        to_d          = to_q;
        from_d        = from_q;
        val_d         = val_q;
        illegal_d     = 1'b0;
        cnt_d         = cnt_q;
        raw_instr_ack = raw_instr_valid &&
                        (state_q == S_DECODE || state_q == S_LONG_WAIT);
        case (state_q)
            S_DECODE: begin
                if (raw_instr_ack) begin
                    if (f_single) begin
                        ch_d    = f_ch;
                        to_d    = f_to;
                        from_d  = f_from;
                        state_d = S_OUT;
                        case (f_ch)
                            CH_IMM:    val_d = f_simm;
                            CH_JUMP:   val_d = f_jptr;
                            CH_BRANCH: val_d = f_bptr;
                            default:   val_d = '0;
                        endcase
                    end else if (f_long) begin
                        to_d    = f_to;
                        state_d = S_LONG_WAIT;
                    end else begin
                        illegal_d = 1'b1;
                        if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_LONG_WAIT: begin
                if (raw_instr_ack) begin
                    ch_d    = CH_IMM;
                    val_d   = raw_instr_data;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (ch_ack) state_d = S_DECODE;
            end
            default: state_d = S_DECODE;
        endcase
    end

    // State, output register and counter; reset also drops any half-received long immediate.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_DECODE;
            ch_q      <= CH_MOVE;
            to_q      <= '0;
            from_q    <= '0;
            val_q     <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            to_q      <= to_d;
            from_q    <= from_d;
            val_q     <= val_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // Exactly one channel valid in S_OUT; data fields forced to zero whenever their valid is low.
    always_comb begin
        out_vld         = (state_q == S_OUT);
        move_valid      = out_vld && (ch_q == CH_MOVE);
        immediate_valid = out_vld && (ch_q == CH_IMM);
        jump_valid      = out_vld && (ch_q == CH_JUMP);
        branch_valid    = out_vld && (ch_q == CH_BRANCH);
        move_from       = move_valid      ? from_q : '0;
        move_to         = move_valid      ? to_q   : '0;
        immediate_addr  = immediate_valid ? to_q   : '0;
        immediate       = immediate_valid ? val_q  : '0;
        jump_ptr        = jump_valid      ? val_q  : '0;
        branch_ptr      = branch_valid    ? val_q  : '0;
        illegal         = illegal_q;
        illegal_count   = cnt_q;
    end

endmodule

// File: tb/tb_cu_pipelined_instr_decode.sv
// Self-checking bench for cu_pipelined_instr_decode: vector table, hand sequences, randomized model check.
module tb_cu_pipelined_instr_decode;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int JW = 16;
    localparam int CW = 4;   // narrow counter so saturation is reachable

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] raw_instr_data;
    logic          raw_instr_valid;
    logic          raw_instr_ack;
    logic [DW-1:0] jump_ptr, branch_ptr, immediate;
    logic          jump_valid, branch_valid, move_valid, immediate_valid;
    logic          jump_ack, branch_ack, move_ack, immediate_ack;
    logic [AW-1:0] move_from, move_to, immediate_addr;
    logic          illegal;
    logic [CW-1:0] illegal_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    // ch: 0 move, 1 immediate, 2 jump, 3 branch, 4 illegal; a=from, b=to/addr, v=imm/ptr
    typedef struct {
        logic [31:0] w;
        logic [31:0] w2;
        bit          lng;
        int          ch;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] v;
    } vec_t;

    cu_pipelined_instr_decode #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .JUMP_PTR_WIDTH(JW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .raw_instr_data(raw_instr_data), .raw_instr_valid(raw_instr_valid), .raw_instr_ack(raw_instr_ack),
        .jump_ptr(jump_ptr), .jump_valid(jump_valid), .jump_ack(jump_ack),
        .branch_ptr(branch_ptr), .branch_valid(branch_valid), .branch_ack(branch_ack),
        .move_valid(move_valid), .move_from(move_from), .move_to(move_to), .move_ack(move_ack),
        .immediate_valid(immediate_valid), .immediate_addr(immediate_addr), .immediate(immediate),
        .immediate_ack(immediate_ack),
        .illegal(illegal), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Decode from the instruction-format rules using plain arithmetic on the word value.
    function automatic vec_t ref_decode(input logic [31:0] w, input logic [31:0] w2);
        vec_t e;
        int unsigned op;
        op    = w % 8;
        e.w   = w;
        e.w2  = w2;
        e.lng = (op == 2);
        e.a   = 8'((w / 2048) % 256);
        e.b   = 8'((w / 8) % 256);
        e.v   = 0;
        case (op)
            0: e.ch = 0;
            1: begin e.ch = 1; e.v = w / 2048; end
            2: begin e.ch = 1; e.v = w2; end
            3: begin e.ch = 2; e.v = (w / 8) % 65536; end
            4: begin e.ch = 3; e.v = w / 8; end
            default: e.ch = 4;
        endcase
        return e;
    endfunction

    task automatic chk_outs(input vec_t e, input bit act, input string tag);
        bit m, i, j, b;
        m = act && e.ch == 0;
        i = act && e.ch == 1;
        j = act && e.ch == 2;
        b = act && e.ch == 3;
        chk({tag, ".move_valid"}, move_valid, m);
        chk({tag, ".move_from"},  move_from,  m ? e.a : 8'h0);
        chk({tag, ".move_to"},    move_to,    m ? e.b : 8'h0);
        chk({tag, ".imm_valid"},  immediate_valid, i);
        chk({tag, ".imm_addr"},   immediate_addr,  i ? e.b : 8'h0);
        chk({tag, ".imm"},        immediate,       i ? e.v : 32'h0);
        chk({tag, ".jump_valid"}, jump_valid, j);
        chk({tag, ".jump_ptr"},   jump_ptr,   j ? e.v : 32'h0);
        chk({tag, ".br_valid"},   branch_valid, b);
        chk({tag, ".br_ptr"},     branch_ptr,   b ? e.v : 32'h0);
    endtask

    task automatic set_ack(input int ch, input logic v);
        case (ch)
            0: move_ack      = v;
            1: immediate_ack = v;
            2: jump_ack      = v;
            3: branch_ack    = v;
            default: ;
        endcase
    endtask

    // Send one instruction (one or two words), check output, hold for `hold` cycles, then ack.
    task automatic run_instr(input vec_t e, input int hold, input string tag);
        raw_instr_valid = 1'b1;
        raw_instr_data  = e.w;
        #1 chk({tag, ".ack_hdr"}, raw_instr_ack, 1);
        tick;
        if (e.lng) begin
            chk({tag, ".long_idle"}, immediate_valid, 0);
            raw_instr_data = e.w2;
            #1 chk({tag, ".ack_imm"}, raw_instr_ack, 1);
            tick;
        end
        raw_instr_valid = 1'b0;
        raw_instr_data  = '0;
        if (e.ch == 4) begin
            exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
            chk({tag, ".illegal"}, illegal, 1);
            chk({tag, ".ill_cnt"}, illegal_count, exp_cnt);
            chk_outs(e, 0, tag);
            tick;
            chk({tag, ".illegal_drop"}, illegal, 0);
            return;
        end
        chk_outs(e, 1, tag);
        chk({tag, ".no_illegal"}, illegal, 0);
        if (hold > 0) begin
            repeat (hold) tick;
            chk_outs(e, 1, {tag, ".held"});
        end
        set_ack(e.ch, 1'b1);
        tick;
        set_ack(e.ch, 1'b0);
        chk_outs(e, 0, {tag, ".after_ack"});
    endtask

    vec_t tbl[7];
    vec_t e, mv, im;

    initial begin
        tbl[0] = '{w: 32'h000091A0, w2: 0, lng: 0, ch: 0, a: 8'h12, b: 8'h34, v: 0};
        tbl[1] = '{w: 32'hFFFFFBF9, w2: 0, lng: 0, ch: 1, a: 8'h0,  b: 8'h7F, v: 32'h001FFFFF};
        tbl[2] = '{w: 32'h00091A2B, w2: 0, lng: 0, ch: 2, a: 8'h0,  b: 8'h0,  v: 32'h00002345};
        tbl[3] = '{w: 32'h0D5E6F7C, w2: 0, lng: 0, ch: 3, a: 8'h0,  b: 8'h0,  v: 32'h01ABCDEF};
        tbl[4] = '{w: 32'hFFFFFFFB, w2: 0, lng: 0, ch: 2, a: 8'h0,  b: 8'h0,  v: 32'h0000FFFF};
        tbl[5] = '{w: 32'hFFFFFFFC, w2: 0, lng: 0, ch: 3, a: 8'h0,  b: 8'h0,  v: 32'h1FFFFFFF};
        tbl[6] = '{w: 32'h0000002A, w2: 32'hDEADBEEF, lng: 1, ch: 1, a: 8'h0, b: 8'h05, v: 32'hDEADBEEF};

        reset = 1'b1;
        raw_instr_data = '0;
        raw_instr_valid = 1'b0;
        move_ack = 1'b0; immediate_ack = 1'b0; jump_ack = 1'b0; branch_ack = 1'b0;
        e = tbl[0];
        repeat (3) tick;
        chk_outs(e, 0, "reset");
        chk("reset.illegal", illegal, 0);
        chk("reset.cnt", illegal_count, 0);
        chk("reset.raw_ack", raw_instr_ack, 0);
        reset = 1'b0;

        // stray acks while idle must not disturb anything
        move_ack = 1'b1; jump_ack = 1'b1; immediate_ack = 1'b1; branch_ack = 1'b1;
        tick;
        move_ack = 1'b0; jump_ack = 1'b0; immediate_ack = 1'b0; branch_ack = 1'b0;
        chk_outs(e, 0, "idle_ack");

        for (int k = 0; k < 7; k++) run_instr(tbl[k], k % 3, $sformatf("vec%0d", k));

        // three illegal words back to back
        raw_instr_valid = 1'b1;
        raw_instr_data  = 32'h00000007;
        for (int k = 1; k <= 3; k++) begin
            tick;
            chk($sformatf("ill%0d.pulse", k), illegal, 1);
            chk($sformatf("ill%0d.cnt", k), illegal_count, k);
            chk_outs(e, 0, $sformatf("ill%0d", k));
        end
        raw_instr_valid = 1'b0;
        exp_cnt = 3;
        tick;
        chk("ill.drop", illegal, 0);
        chk("ill.cnt_hold", illegal_count, 3);

        // backpressure: MOVE held 5 cycles with a word waiting; the wrong channel's ack is ignored
        mv = tbl[0];
        im = tbl[1];
        raw_instr_valid = 1'b1;
        raw_instr_data  = mv.w;
        tick;
        raw_instr_data  = im.w;
        jump_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d.raw_ack", k), raw_instr_ack, 0);
            chk_outs(mv, 1, $sformatf("bp%0d", k));
            tick;
        end
        jump_ack = 1'b0;
        move_ack = 1'b1;
        #1 chk("bp.ack_cycle_raw_ack", raw_instr_ack, 0);
        tick;
        move_ack = 1'b0;
        chk("bp.released_valid", move_valid, 0);
        chk("bp.next_accept", raw_instr_ack, 1);
        tick;
        raw_instr_valid = 1'b0;
        chk_outs(im, 1, "bp.next");
        immediate_ack = 1'b1;
        tick;
        immediate_ack = 1'b0;
        chk_outs(im, 0, "bp.done");

        // randomized instructions against the reference decode
        for (int k = 0; k < 150; k++) begin
            logic [31:0] w;
            w = ($urandom & 32'hFFFFFFF8) | 32'($urandom_range(0, 7));
            run_instr(ref_decode(w, $urandom), int'($urandom_range(0, 3)), $sformatf("rnd%0d", k));
        end

        // counter saturation
        raw_instr_valid = 1'b1;
        raw_instr_data  = 32'h0000000D;
        repeat (20) tick;
        raw_instr_valid = 1'b0;
        chk("sat.cnt", illegal_count, 15);
        tick;
        chk("sat.cnt_hold", illegal_count, 15);

        // reset while waiting for the long immediate word
        raw_instr_valid = 1'b1;
        raw_instr_data  = 32'h0000002A;
        tick;
        raw_instr_valid = 1'b0;
        tick;
        chk_outs(e, 0, "lw.wait");
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_cnt = 0;
        chk("lw.cnt_cleared", illegal_count, 0);
        chk_outs(e, 0, "lw.after_reset");
        run_instr(tbl[0], 0, "lw.move");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cu_pipelined_instr_decode.md
# cu_pipelined_instr_decode

Registered, parametrised instruction decoder for the control unit. It sits between instruction fetch (`raw_instr`) and the move/immediate issue path (`to_mib`) and the jump/branch pointer ports. Compared with the combinational decoder it has a 3-bit opcode and a two-word long-immediate instruction. It counts illegal opcodes, and it holds each decoded instruction in an output register until the destination acknowledges it.

## Interface
- `ADDR_WIDTH`, 8: width of move/immediate address fields.
- `DATA_WIDTH`, 32: instruction word, immediate and pointer width.
- `JUMP_PTR_WIDTH`, 16: low bits of the jump destination forwarded on `jump.ptr`; the rest is zero-filled.
- `CNT_WIDTH`, 16: width of the illegal-opcode counter.
- `clk` in 1: the block's single clock.
- `reset` in 1: synchronous, active-high.
- `raw_instr` data_interface.consumer DATA_WIDTH: fetched instruction words.
- `jump` pointer_interface.producer DATA_WIDTH: jump target.
- `branch` pointer_interface.producer DATA_WIDTH: branch target.
- `to_mib` instruction_interface.producer: move and immediate issue.
- `illegal` out 1: one-cycle pulse when an illegal opcode is consumed.
- `illegal_count` out CNT_WIDTH: saturating count of illegal opcodes.

## Operation
- Encoding, OP_BITS=3:
  - op = data[2:0].
  - to = data[ADDR_WIDTH+2:3].
  - from = data[2*ADDR_WIDTH+2:ADDR_WIDTH+3].
  - short immediate = data[DATA_WIDTH-1:ADDR_WIDTH+3].
  - dest = data[DATA_WIDTH-1:3].
- Opcodes:
  - MOVE 000.
  - IMM 001: short immediate, zero-extended to DATA_WIDTH.
  - IMM_LONG 010: the header carries `to`; the next word is the full DATA_WIDTH immediate.
  - JUMP 011: ptr = zero-extended dest[JUMP_PTR_WIDTH-1:0].
  - BRANCH 100: ptr = zero-extended dest.
  - 101–111 are illegal.
- FSM states:
  - S_DECODE, accepting a header:
    - legal single-word op: latch the fields into the output register, go to S_OUT.
    - IMM_LONG: latch `to`, go to S_LONG_WAIT.
    - illegal op: consume the word, pulse `illegal`, increment the counter (saturating at all-ones), stay in S_DECODE.
  - S_LONG_WAIT: accept the next word as the immediate, go to S_OUT.
  - S_OUT: assert the valid of exactly one output channel. On that channel's ack, clear the valid and go to S_DECODE.
- `raw_instr.ack` = `raw_instr.valid` && state ∈ {S_DECODE, S_LONG_WAIT}. It is combinational, and acceptance happens in the same cycle.
- No word is accepted in S_OUT, so there is at most one outstanding decoded instruction.
- Output data fields are zero whenever their valid is low.
- All output fields are stable from valid rise until the ack cycle.
- `reset` in any state:
  - returns to S_DECODE;
  - clears every valid, the latched fields, `illegal` and `illegal_count`;
  - discards a half-received long immediate.

## Timing
- Reset values: `move_valid`, `immediate_valid`, `jump.valid`, `branch.valid`, `raw_instr.ack` (state-driven), `illegal` = 0; all data outputs 0; `illegal_count` = 0.
- Latency:
  - single-word op accepted in cycle N: output valid in cycle N+1.
  - long immediate with header in N and immediate word in M > N: output valid in M+1.
- Throughput: at best one single-word instruction per 2 cycles (accept, then ack in S_OUT).
- Ack in the same cycle valid rises: valid clears next cycle, and the next accept is possible that cycle.
- Downstream ack while the channel is not valid is ignored.
- `raw_instr.valid` low in S_LONG_WAIT: wait indefinitely with no timeout.
- Illegal header: accept in cycle N, `illegal` high in N+1, `illegal_count` incremented in N+1.
- Counter saturates at 2^CNT_WIDTH−1; no wrap.

## Structure
- Shared package `cu_decode_pkg`:
  - OP_BITS and the opcode localparams (OP_MOVE…OP_BRANCH);
  - state enum `cu_dec_state_t` {S_DECODE, S_LONG_WAIT, S_OUT};
  - output-channel enum {CH_MOVE, CH_IMM, CH_JUMP, CH_BRANCH}.
- Sub-module `cu_decode_fields`: purely combinational field extraction and opcode classification from one word. The FSM, output register and counter live in the top module.

## Test plan
Defaults apply in every scenario.
- MOVE: `raw_instr.data`=0x000091A0 (from 0x12, to 0x34) -> ack that cycle; next cycle `move_valid`=1, `move_from`=0x12, `move_to`=0x34.
- Long immediate: header 0x0000002A, then 0xDEADBEEF -> ack on both; `immediate_valid`=1, `immediate_addr`=0x05, `immediate`=0xDEADBEEF.
- JUMP: data = (0x12345<<3)|3 -> `jump.ptr`=0x00002345, `jump.valid`=1.
- Illegal: data 0x00000007 three times -> three `illegal` pulses, `illegal_count`=3, no channel valid.
- Backpressure: MOVE issued, `move_ack` held low for 5 cycles with the next word waiting -> `move_valid` and fields stable, `raw_instr.ack`=0 throughout; one cycle after ack, the next word is accepted.
- Reset in S_LONG_WAIT: after header 0x2A, pulse `reset`, then send 0x000091A0 -> decoded as MOVE, not as an immediate.
